sram_like_arbiter: RTL and testbench

Two-master to one-slave arbiter for the SRAM-like memory interface. It shares a single memory port between the instruction-fetch master and the data-access master used by the load/store stage. It adds no cycles to the request path. It records which master owns each accepted request, so the in-order `data_ok`/`rdata` responses are routed back to the correct master. It sits between the CPU core and the SRAM-like-to-AXI bridge.

---
 rtl/sram_like_arbiter.sv | 214 +++++++++++++++++++++
 tb/tb_sram_like_arbiter.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/sram_like_arbiter.sv
// sram_like_arbiter: shares one SRAM-like memory port between the inst-fetch and data masters.
// Latency: request path is combinational (0 cycles); responses route back in the cycle of mem_data_ok.
// Backpressure: masters hold req until addr_ok; mem_req is masked while OUTS_DEPTH requests are outstanding.
// Optional macro ARB_ROUND_ROBIN_EN: round-robin when both masters request (default: data always wins).
module sram_like_arbiter #(
    parameter int OUTS_DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         inst_req,
    input  logic                         inst_wr,
    input  logic [1:0]                   inst_size,
    input  logic [31:0]                  inst_addr,
    input  logic [31:0]                  inst_wdata,
    output logic                         inst_addr_ok,
    output logic                         inst_data_ok,
    output logic [31:0]                  inst_rdata,
    input  logic                         data_req,
    input  logic                         data_wr,
    input  logic [1:0]                   data_size,
    input  logic [31:0]                  data_addr,
    input  logic [31:0]                  data_wdata,
    output logic                         data_addr_ok,
    output logic                         data_data_ok,
    output logic [31:0]                  data_rdata,
    output logic                         mem_req,
    output logic                         mem_wr,
    output logic [1:0]                   mem_size,
    output logic [31:0]                  mem_addr,
    output logic [31:0]                  mem_wdata,
    input  logic                         mem_addr_ok,
    input  logic                         mem_data_ok,
    input  logic [31:0]                  mem_rdata,
    output logic [$clog2(OUTS_DEPTH):0]  outs_cnt
);

    localparam int PW = $clog2(OUTS_DEPTH);
    localparam logic [PW:0] DEPTH_CNT = (PW+1)'(OUTS_DEPTH);

    typedef enum logic [1:0] {
        ARB_IDLE   = 2'd0,
        ARB_HOLD_I = 2'd1,
        ARB_HOLD_D = 2'd2
    } arb_state_e;

    arb_state_e              state_q, state_d;
    logic [PW:0]             cnt_q, cnt_d;
    logic [PW-1:0]           wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]           rd_ptr_q, rd_ptr_d;
    logic [OUTS_DEPTH-1:0]   owner_q;

    logic grant_vld;
    logic grant_data;
    logic pick_data;
    logic granted_req;
    logic full;
    logic empty;
    logic mem_req_int;
    logic accept;
    logic pop;
    logic head_owner;

    assign full  = (cnt_q == DEPTH_CNT);
    assign empty = (cnt_q == '0);

`ifdef ARB_ROUND_ROBIN_EN
    // Owner of the most recent accepted request (1 = data); reset value favours data.
    logic last_data_q;

    // Track the last accepted owner for round-robin tie breaking.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_data_q <= 1'b0;
        end else if (accept) begin
            last_data_q <= grant_data;
        end
    end

    assign pick_data = data_req & (~inst_req | ~last_data_q);
`else
    assign pick_data = data_req;
`endif

    // Grant state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ARB_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Grant selection and next state; a grant is locked until the slave accepts or the master withdraws.
    always_comb begin
        state_d    = state_q;
        grant_vld  = 1'b0;
        grant_data = 1'b0;
        case (state_q)
            ARB_IDLE: begin
                if ((inst_req | data_req) && !full) begin
                    grant_vld  = 1'b1;
                    grant_data = pick_data;
                    if (!mem_addr_ok) begin
                        state_d = pick_data ? ARB_HOLD_D : ARB_HOLD_I;
                    end
                end
            end
            ARB_HOLD_I: begin
                grant_vld  = 1'b1;
                grant_data = 1'b0;
                if (mem_addr_ok || !inst_req) begin
                    state_d = ARB_IDLE;
                end
            end
            ARB_HOLD_D: begin
                grant_vld  = 1'b1;
                grant_data = 1'b1;
                if (mem_addr_ok || !data_req) begin
                    state_d = ARB_IDLE;
                end
            end
            default: begin
                state_d = ARB_IDLE;
            end
        endcase
    end

    assign granted_req = grant_vld & (grant_data ? data_req : inst_req);
    assign mem_req_int = granted_req & ~full;
    assign accept      = mem_req_int & mem_addr_ok;
    // Responses with nothing outstanding are dropped rather than popping an empty FIFO.
    assign pop         = mem_data_ok & ~empty;
    assign head_owner  = owner_q[rd_ptr_q];

    // Owner FIFO pointer and count bookkeeping; a push and pop together leave the count unchanged.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (accept) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        if (accept && !pop) begin
            cnt_d = cnt_q + (PW+1)'(1);
        end else if (!accept && pop) begin
            cnt_d = cnt_q - (PW+1)'(1);
        end
    end

    // Owner FIFO pointers and count registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    // Owner FIFO storage: one bit per accepted request, 1 = data master.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            owner_q <= '0;
        end else if (accept) begin
            owner_q[wr_ptr_q] <= grant_data;
        end
    end

    // Output steering; everything is forced low while reset is asserted.
    always_comb begin
        mem_req      = 1'b0;
        mem_wr       = 1'b0;
        mem_size     = 2'd0;
        mem_addr     = 32'd0;
        mem_wdata    = 32'd0;
        inst_addr_ok = 1'b0;
        data_addr_ok = 1'b0;
        inst_data_ok = 1'b0;
        data_data_ok = 1'b0;
        inst_rdata   = 32'd0;
        data_rdata   = 32'd0;
        if (!reset) begin
            mem_req = mem_req_int;
            if (grant_vld) begin
                if (grant_data) begin
                    mem_wr    = data_wr;
                    mem_size  = data_size;
                    mem_addr  = data_addr;
                    mem_wdata = data_wdata;
                end else begin
                    mem_wr    = inst_wr;
                    mem_size  = inst_size;
                    mem_addr  = inst_addr;
                    mem_wdata = inst_wdata;
                end
            end
            inst_addr_ok = accept & ~grant_data;
            data_addr_ok = accept &  grant_data;
            inst_data_ok = pop & ~head_owner;
            data_data_ok = pop &  head_owner;
            inst_rdata   = mem_rdata;
            data_rdata   = mem_rdata;
        end
    end

    assign outs_cnt = cnt_q;

endmodule

// File: tb/tb_sram_like_arbiter.sv
// tb_sram_like_arbiter: random two-master traffic against a queue-based reference of the arbiter.
// Latency: outputs are checked on the falling edge of the cycle the inputs are applied.
// Backpressure: masters hold requests until the reference says they were accepted.
module tb_sram_like_arbiter;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        inst_req, inst_wr, inst_addr_ok, inst_data_ok;
    logic [1:0]  inst_size;
    logic [31:0] inst_addr, inst_wdata, inst_rdata;
    logic        data_req, data_wr, data_addr_ok, data_data_ok;
    logic [1:0]  data_size;
    logic [31:0] data_addr, data_wdata, data_rdata;
    logic        mem_req, mem_wr, mem_addr_ok, mem_data_ok;
    logic [1:0]  mem_size;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [2:0]  outs_cnt;

    always #5 clk = ~clk;

    sram_like_arbiter #(.OUTS_DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset),
        .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size),
        .inst_addr(inst_addr), .inst_wdata(inst_wdata),
        .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
        .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
        .data_addr(data_addr), .data_wdata(data_wdata),
        .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
        .mem_req(mem_req), .mem_wr(mem_wr), .mem_size(mem_size),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_addr_ok(mem_addr_ok), .mem_data_ok(mem_data_ok), .mem_rdata(mem_rdata),
        .outs_cnt(outs_cnt)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Reference state: owners of accepted-but-unanswered requests in order (0 inst, 1 data),
    // the master whose presented request is still waiting (-1 none), and the last accepted owner.
    int q_own[$];
    int waiting  = -1;
    int last_own = 0;
    bit acc_i    = 1'b0;
    bit acc_d    = 1'b0;
    int req_pct, aok_pct, dok_pct;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int pick_winner();
`ifdef ARB_ROUND_ROBIN_EN
        if (inst_req && data_req) return (last_own == 1) ? 0 : 1;
`endif
        return data_req ? 1 : 0;
    endfunction

    // Check one cycle against the reference, then advance the reference across the clock edge.
    task automatic cycle(input bit in_rst);
        int          own;
        bit          full, ereq, acc, popd;
        int          nxt_wait;
        logic        e_wr;
        logic [1:0]  e_size;
        logic [31:0] e_addr, e_wdata;
        @(negedge clk);
        if (in_rst) begin
            chk("rst_mem_req",   32'(mem_req), 0);
            chk("rst_mem_addr",  mem_addr, 0);
            chk("rst_mem_wdata", mem_wdata, 0);
            chk("rst_i_aok",     32'(inst_addr_ok), 0);
            chk("rst_d_aok",     32'(data_addr_ok), 0);
            chk("rst_i_dok",     32'(inst_data_ok), 0);
            chk("rst_d_dok",     32'(data_data_ok), 0);
            chk("rst_i_rdata",   inst_rdata, 0);
            chk("rst_d_rdata",   data_rdata, 0);
            chk("rst_cnt",       32'(outs_cnt), 0);
            @(posedge clk);
            #1;
            q_own.delete();
            waiting  = -1;
            last_own = 0;
            acc_i    = 1'b0;
            acc_d    = 1'b0;
        end else begin
            full = (q_own.size() == DEPTH);
            if (waiting >= 0)                        own = waiting;
            else if (!full && (inst_req || data_req)) own = pick_winner();
            else                                     own = -1;
            ereq = (own == 1 && data_req && !full) || (own == 0 && inst_req && !full);
            e_wr = 1'b0; e_size = 2'd0; e_addr = 32'd0; e_wdata = 32'd0;
            if (own == 1) begin
                e_wr = data_wr; e_size = data_size; e_addr = data_addr; e_wdata = data_wdata;
            end else if (own == 0) begin
                e_wr = inst_wr; e_size = inst_size; e_addr = inst_addr; e_wdata = inst_wdata;
            end
            acc  = ereq && mem_addr_ok;
            popd = mem_data_ok && (q_own.size() > 0);
            chk("mem_req",   32'(mem_req), 32'(ereq));
            chk("mem_wr",    32'(mem_wr), 32'(e_wr));
            chk("mem_size",  32'(mem_size), 32'(e_size));
            chk("mem_addr",  mem_addr, e_addr);
            chk("mem_wdata", mem_wdata, e_wdata);
            chk("i_aok",     32'(inst_addr_ok), 32'(acc && own == 0));
            chk("d_aok",     32'(data_addr_ok), 32'(acc && own == 1));
            chk("i_dok",     32'(inst_data_ok), 32'(popd && q_own[0] == 0));
            chk("d_dok",     32'(data_data_ok), 32'(popd && q_own[0] == 1));
            chk("i_rdata",   inst_rdata, mem_rdata);
            chk("d_rdata",   data_rdata, mem_rdata);
            chk("outs_cnt",  32'(outs_cnt), 32'(q_own.size()));
            nxt_wait = -1;
            if (own == 0 && inst_req && !mem_addr_ok) nxt_wait = 0;
            if (own == 1 && data_req && !mem_addr_ok) nxt_wait = 1;
            @(posedge clk);
            #1;
            if (popd) void'(q_own.pop_front());
            if (acc) begin
                q_own.push_back(own);
                last_own = own;
            end
            waiting = nxt_wait;
            acc_i   = acc && own == 0;
            acc_d   = acc && own == 1;
        end
    endtask

    task automatic drive_rand();
        reset = 1'b0;
        if (inst_req && !acc_i) begin
            if ($urandom_range(0, 15) == 0) inst_req = 1'b0;
        end else begin
            inst_req   = ($urandom_range(0, 99) < req_pct);
            inst_wr    = 1'($urandom);
            inst_size  = 2'($urandom_range(0, 2));
            inst_addr  = $urandom;
            inst_wdata = $urandom;
        end
        if (data_req && !acc_d) begin
            if ($urandom_range(0, 15) == 0) data_req = 1'b0;
        end else begin
            data_req   = ($urandom_range(0, 99) < req_pct);
            data_wr    = 1'($urandom);
            data_size  = 2'($urandom_range(0, 2));
            data_addr  = $urandom;
            data_wdata = $urandom;
        end
        mem_addr_ok = ($urandom_range(0, 99) < aok_pct);
        if (q_own.size() > 0) mem_data_ok = ($urandom_range(0, 99) < dok_pct);
        else                  mem_data_ok = ($urandom_range(0, 19) == 0);
        mem_rdata = $urandom;
    endtask

    task automatic run_phase(input int cycles, input int rq, input int aok, input int dok, input int rst_every);
        req_pct = rq; aok_pct = aok; dok_pct = dok;
        for (int i = 0; i < cycles; i++) begin
            if (rst_every > 0 && (i % rst_every) == rst_every - 1) begin
                reset = 1'b1;
                cycle(1'b1);
                cycle(1'b1);
            end
            drive_rand();
            cycle(1'b0);
        end
    endtask

    initial begin
        reset = 1'b1;
        inst_req = 0; inst_wr = 0; inst_size = 0; inst_addr = 0; inst_wdata = 0;
        data_req = 0; data_wr = 0; data_size = 0; data_addr = 0; data_wdata = 0;
        mem_addr_ok = 0; mem_data_ok = 0; mem_rdata = 0;
        #1;
        cycle(1'b1);
        reset = 1'b0;

        // Single instruction read answered three cycles after acceptance.
        inst_req = 1; inst_wr = 0; inst_size = 2; inst_addr = 32'hBFC0_0000; mem_addr_ok = 1;
        cycle(1'b0);
        inst_req = 0; mem_addr_ok = 0;
        cycle(1'b0);
        cycle(1'b0);
        mem_data_ok = 1; mem_rdata = 32'h3C1D_0001;
        cycle(1'b0);
        mem_data_ok = 0;

        // Both masters request together; data re-requests once with addr_ok every cycle.
        inst_req = 1; inst_addr = 32'h1000;
        data_req = 1; data_wr = 1; data_size = 2; data_addr = 32'h2000; data_wdata = 32'hDEAD_BEEF;
        mem_addr_ok = 1;
        cycle(1'b0);
        if (acc_i) inst_req = 0;
        data_addr = 32'h2004;
        cycle(1'b0);
        if (acc_i) inst_req = 0;
        if (acc_d) data_req = 0;
        cycle(1'b0);
        inst_req = 0; data_req = 0;
        mem_data_ok = 1;
        repeat (3) cycle(1'b0);
        mem_data_ok = 0;

        // Data held off by the slave for four cycles while inst also requests.
        data_req = 1; data_addr = 32'h2000; mem_addr_ok = 0;
        cycle(1'b0);
        inst_req = 1; inst_addr = 32'h3000;
        repeat (3) cycle(1'b0);
        mem_addr_ok = 1;
        cycle(1'b0);
        data_req = 0;
        cycle(1'b0);
        inst_req = 0; mem_addr_ok = 0; mem_data_ok = 1;
        repeat (2) cycle(1'b0);
        mem_data_ok = 0;

        run_phase(600, 60, 70, 40, 150);
        run_phase(40, 90, 90, 0, 0);
        run_phase(400, 80, 80, 30, 130);
        run_phase(400, 40, 50, 70, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
